sccb_init_sequencer: RTL and testbench

- Sequences camera sensor power-up configuration over SCCB.
- Walks a register table held in an external synchronous ROM and issues one write request per entry to the existing SCCB master.
- Inserts timed delays where the table asks for them and reports done or error status to the APB-visible control logic.
- Sits between the camera driver's APB register block (start/status) and the SCCB master.

---
 rtl/sccb_init_sequencer_if.sv | 24 ++
 rtl/sccb_init_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_sequencer_if.sv
// ROM fetch port and SCCB write-request port of sccb_init_sequencer.
// Handshake: sccb_req rises with sccb_reg/sccb_wdata stable and is held until a
// one-cycle sccb_done (sccb_nack qualified by it) is seen; it drops the following cycle.
interface sccb_init_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              sccb_req;
  logic [15:0]       sccb_reg;
  logic [7:0]        sccb_wdata;
  logic              sccb_done;
  logic              sccb_nack;

  modport master (
    output rom_addr, sccb_req, sccb_reg, sccb_wdata,
    input  rom_data, sccb_done, sccb_nack
  );

  modport slave (
    input  rom_addr, sccb_req, sccb_reg, sccb_wdata,
    output rom_data, sccb_done, sccb_nack
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register table in ROM and issues one SCCB write per entry.
// Optional macro SCCB_RETRY_EN: retry a NACKed entry up to MAX_RETRY times.
module sccb_init_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int PWRUP_CYCLES  = 20000,
  parameter int CYCLES_PER_MS = 50000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  start,
  sccb_init_sequencer_if.master bus,
  output logic                  busy,
  output logic                  init_done,
  output logic                  error,
  output logic [ADDR_W-1:0]     err_index,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PWRUP  = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_ISSUE  = 4'd4,
    S_WAIT   = 4'd5,
    S_DELAY  = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam int PWR_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int DLY_W = $clog2(255 * CYCLES_PER_MS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              req_q, req_d;
  logic [15:0]       reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] err_index_q, err_index_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;

`ifdef SCCB_RETRY_EN
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  logic advance;
  logic to_done;
  logic to_error;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    req_d       = req_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    pwr_cnt_d   = pwr_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    advance     = 1'b0;
    to_done     = 1'b0;
    to_error    = 1'b0;
`ifdef SCCB_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          rom_addr_d  = '0;
          busy_d      = 1'b1;
          pwr_cnt_d   = '0;
          state_d     = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (pwr_cnt_q == PWR_W'(PWRUP_CYCLES - 1)) state_d = S_FETCH;
        else pwr_cnt_d = pwr_cnt_q + 1'b1;
      end
      S_FETCH: begin
`ifdef SCCB_RETRY_EN
        retry_d = '0;
`endif
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (bus.rom_data[23:8] == 16'hFFFF) begin
          to_done = 1'b1;
        end else if (bus.rom_data[23:8] == 16'hFFFE) begin
          if (bus.rom_data[7:0] == 8'd0) advance = 1'b1;
          else begin
            dly_cnt_d = DLY_W'(bus.rom_data[7:0]) * DLY_W'(CYCLES_PER_MS);
            state_d   = S_DELAY;
          end
        end else begin
          reg_d   = bus.rom_data[23:8];
          wdata_d = bus.rom_data[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sccb_done) begin
          req_d = 1'b0;
          if (!bus.sccb_nack) advance = 1'b1;
          else begin
`ifdef SCCB_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_ISSUE;
            end else begin
              to_error = 1'b1;
            end
`else
            to_error = 1'b1;
`endif
          end
        end
      end
      S_DELAY: begin
        if (dly_cnt_q <= DLY_W'(1)) advance = 1'b1;
        else dly_cnt_d = dly_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The last table slot ends the walk rather than wrapping back to entry 0.
    if (advance) begin
      if (rom_addr_q == LAST_ADDR) to_done = 1'b1;
      else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = S_FETCH;
      end
    end
    if (to_done) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (to_error) begin
      state_d     = S_ERROR;
      busy_d      = 1'b0;
      error_d     = 1'b1;
      err_index_d = rom_addr_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      req_q       <= 1'b0;
      reg_q       <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      pwr_cnt_q   <= '0;
      dly_cnt_q   <= '0;
`ifdef SCCB_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      req_q       <= req_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      pwr_cnt_q   <= pwr_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
`ifdef SCCB_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sccb_req   = req_q;
  assign bus.sccb_reg   = reg_q;
  assign bus.sccb_wdata = wdata_q;
  assign busy           = busy_q;
  assign init_done      = done_q;
  assign error          = error_q;
  assign err_index      = err_index_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: 4-entry ROM, short power-up and ms timing.
// Build with +define+SCCB_RETRY_EN to check the retry variant.
module tb_sccb_init_sequencer;

  localparam int ADDR_W        = 2;
  localparam int PWRUP_CYCLES  = 5;
  localparam int CYCLES_PER_MS = 10;
  localparam int MAX_RETRY     = 3;

  typedef struct packed {
    logic [3:0][23:0] rom;
    int               nack_idx;
    int               nack_times;
    int               exp_n;
    logic [4:0][23:0] exp_req;
    logic             exp_done;
    logic             exp_err;
    int               exp_eidx;
    int               exp_lat;    // cycles from start edge to first sccb_req, 0 = unchecked
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              init_done;
  logic              error;
  logic [ADDR_W-1:0] err_index;
  logic [3:0]        dbg_state;

  sccb_init_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  sccb_init_sequencer #(
    .ADDR_W       (ADDR_W),
    .PWRUP_CYCLES (PWRUP_CYCLES),
    .CYCLES_PER_MS(CYCLES_PER_MS),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .CLK      (clk),
    .RESETn   (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .init_done(init_done),
    .error    (error),
    .err_index(err_index),
    .dbg_state(dbg_state)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          start_cyc;
  int          first_lat;
  int          req_cnt;
  int          nack_idx;
  int          nack_left;
  bit          resp_en;
  logic [23:0] rom_mem [4];
  logic [23:0] exp_q[$];
  vec_t        vecs [8];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- SCCB master model + scoreboard ----------------
  initial begin
    logic [23:0] got;
    logic        nack;
    bus.sccb_done = 1'b0;
    bus.sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && bus.sccb_req) begin
        got = {bus.sccb_reg, bus.sccb_wdata};
        req_cnt++;
        if (first_lat < 0) first_lat = cyc - start_cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_req: got %06h, required no request", got);
        end else if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_req_content: got %06h, required %06h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        repeat (2) @(negedge clk);
        nack = (int'(bus.rom_addr) == nack_idx) && (nack_left > 0);
        if (nack) nack_left--;
        bus.sccb_done = 1'b1;
        bus.sccb_nack = nack;
        @(negedge clk);
        bus.sccb_done = 1'b0;
        bus.sccb_nack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", id);
    for (int i = 0; i < 4; i++) rom_mem[i] = v.rom[i];
    exp_q.delete();
    for (int i = 0; i < v.exp_n; i++) exp_q.push_back(v.exp_req[i]);
    nack_idx  = v.nack_idx;
    nack_left = v.nack_times;
    req_cnt   = 0;
    first_lat = -1;
    resp_en   = 1'b1;
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check({tag, "_init_done"}, 32'(init_done), 32'(v.exp_done));
    check({tag, "_error"}, 32'(error), 32'(v.exp_err));
    check({tag, "_err_index"}, 32'(err_index), 32'(v.exp_eidx));
    check({tag, "_req_count"}, 32'(req_cnt), 32'(v.exp_n));
    check({tag, "_missing_reqs"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_req_idle"}, 32'(bus.sccb_req), 32'd0);
    if (v.exp_lat > 0) check({tag, "_first_req_latency"}, 32'(first_lat), 32'(v.exp_lat));
  endtask

  function automatic vec_t mk(input logic [23:0] e0, e1, e2, e3, input int ni, nt, n,
                              input logic [23:0] r0, r1, r2, r3, r4,
                              input logic d, er, input int ei, lat);
    vec_t v;
    v.rom        = {e3, e2, e1, e0};
    v.nack_idx   = ni;
    v.nack_times = nt;
    v.exp_n      = n;
    v.exp_req    = {r4, r3, r2, r1, r0};
    v.exp_done   = d;
    v.exp_err    = er;
    v.exp_eidx   = ei;
    v.exp_lat    = lat;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    localparam logic [23:0] E = 24'hFFFF00;
    localparam logic [23:0] Z = 24'h000000;
    start     = 1'b0;
    rst_n     = 1'b0;
    resp_en   = 1'b0;
    nack_idx  = -1;
    nack_left = 0;
    req_cnt   = 0;
    first_lat = -1;
    start_cyc = 0;
    for (int i = 0; i < 4; i++) rom_mem[i] = E;

    // Latency 8 = 5 power-up cycles + FETCH + DECODE + ISSUE; a 2 ms delay adds 20 + its own FETCH/DECODE.
    vecs[0] = mk(24'h300882, 24'h310303, E, E, -1, 0, 2,
                 24'h300882, 24'h310303, Z, Z, Z, 1'b1, 1'b0, 0, 8);
    vecs[1] = mk(24'hFFFE02, 24'h300802, E, E, -1, 0, 1,
                 24'h300802, Z, Z, Z, Z, 1'b1, 1'b0, 0, 30);
`ifdef SCCB_RETRY_EN
    vecs[2] = mk(24'h300882, 24'h310303, E, E, 1, 1000, 5,
                 24'h300882, 24'h310303, 24'h310303, 24'h310303, 24'h310303, 1'b0, 1'b1, 1, 8);
    vecs[3] = mk(24'h300882, 24'h310303, E, E, 1, 2, 4,
                 24'h300882, 24'h310303, 24'h310303, 24'h310303, Z, 1'b1, 1'b0, 0, 8);
    vecs[7] = mk(24'h300882, 24'h310303, E, E, 0, 1000, 4,
                 24'h300882, 24'h300882, 24'h300882, 24'h300882, Z, 1'b0, 1'b1, 0, 8);
`else
    vecs[2] = mk(24'h300882, 24'h310303, E, E, 1, 1000, 2,
                 24'h300882, 24'h310303, Z, Z, Z, 1'b0, 1'b1, 1, 8);
    vecs[3] = mk(24'h300882, 24'h310303, E, E, 1, 2, 2,
                 24'h300882, 24'h310303, Z, Z, Z, 1'b0, 1'b1, 1, 8);
    vecs[7] = mk(24'h300882, 24'h310303, E, E, 0, 1000, 1,
                 24'h300882, Z, Z, Z, Z, 1'b0, 1'b1, 0, 8);
`endif
    vecs[4] = mk(24'h111111, 24'h222222, 24'h333333, 24'h444444, -1, 0, 4,
                 24'h111111, 24'h222222, 24'h333333, 24'h444444, Z, 1'b1, 1'b0, 0, 8);
    vecs[5] = mk(24'hFFFE00, 24'h55555A, E, E, -1, 0, 1,
                 24'h55555A, Z, Z, Z, Z, 1'b1, 1'b0, 0, 10);
    vecs[6] = mk(E, 24'h123456, E, E, -1, 0, 0,
                 Z, Z, Z, Z, Z, 1'b1, 1'b0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_sccb_req", 32'(bus.sccb_req), 32'd0);
    check("rst_sccb_reg", 32'(bus.sccb_reg), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // start during WAIT is ignored; reset during a pending request clears everything
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) rom_mem[i] = vecs[0].rom[i];
    pulse_start();
    for (int i = 0; i < 100 && !bus.sccb_req; i++) @(negedge clk);
    check("wait_req_seen", 32'(bus.sccb_req), 32'd1);
    check("wait_state", 32'(dbg_state), 32'd5);
    pulse_start();
    repeat (3) @(negedge clk);
    check("wait_start_ignored_req", 32'(bus.sccb_req), 32'd1);
    check("wait_start_ignored_state", 32'(dbg_state), 32'd5);
    check("wait_start_ignored_addr", 32'(bus.rom_addr), 32'd0);
    check("wait_req_reg", 32'({bus.sccb_reg, bus.sccb_wdata}), 32'h300882);
    rst_n = 1'b0;
    @(negedge clk);
    check("wait_rst_req", 32'(bus.sccb_req), 32'd0);
    check("wait_rst_busy", 32'(busy), 32'd0);
    check("wait_rst_state", 32'(dbg_state), 32'd0);
    check("wait_rst_reg", 32'({bus.sccb_reg, bus.sccb_wdata}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(dbg_state), 32'd0);
    run_vec(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
